// File: rtl/avalon_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing PIO input block.
interface avalon_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_in_edge.sv
// PIO input port: synchronizer, optional per-bit debounce, edge capture
// with write-1-to-clear, interrupt mask and a registered Avalon-MM read path.
module avalon_pio_in_edge #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits are not stored when WIDTH < 32.
  assign unused_wdata = ^bus.writedata;

  // Shift chain; the oldest stage is the synchronized value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_d = sync_val;
    end else begin : g_debounce
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

      // Accept a new level only after it has differed for N straight cycles.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int unsigned b = 0; b < WIDTH; b++) begin
          if (sync_val[b] == stable_q[b]) begin
            cnt_d[b] = '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            stable_d[b] = sync_val[b];
            cnt_d[b]    = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CW'(1);
          end
        end
      end

      // Per-bit stability counters.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  // Edge detection on the accepted (stable) value.
  always_comb begin
    edge_event = '0;
    if (EDGE_MODE == 0) begin
      edge_event = stable_d & ~stable_q;
    end else if (EDGE_MODE == 1) begin
      edge_event = ~stable_d & stable_q;
    end else begin
      edge_event = stable_d ^ stable_q;
    end
  end

  // Register writes, capture update (set beats clear), irq and read mux.
  always_comb begin
    clr     = '0;
    mask_d  = mask_q;
    rdata_d = '0;
    if (wr_en && (bus.address == 2'd3)) begin
      clr = wdata;
    end
    if (wr_en && (bus.address == 2'd2)) begin
      mask_d = wdata;
    end
    edge_d = (edge_q & ~clr) | edge_event;
    irq_d  = |(edge_d & mask_d);
    case (bus.address)
      2'd0:    rdata_d = DW'(stable_q);
      2'd2:    rdata_d = DW'(mask_q);
      2'd3:    rdata_d = DW'(edge_q);
      default: rdata_d = '0;
    endcase
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for avalon_pio_in_edge: four instances (bypass/rise, debounce 4/rise,
// bypass/fall, bypass/any) share stimulus and are checked against a
// window-based behavioural model plus directed expectations.
module tb_avalon_pio_in_edge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_port;
  int         tests = 0;
  int         fails = 0;

  avalon_pio_in_edge_if bus0 ();
  avalon_pio_in_edge_if bus1 ();
  avalon_pio_in_edge_if bus2 ();
  avalon_pio_in_edge_if bus3 ();

  assign bus1.address = bus0.address;  assign bus1.chipselect = bus0.chipselect;
  assign bus1.write_n = bus0.write_n;  assign bus1.writedata  = bus0.writedata;
  assign bus2.address = bus0.address;  assign bus2.chipselect = bus0.chipselect;
  assign bus2.write_n = bus0.write_n;  assign bus2.writedata  = bus0.writedata;
  assign bus3.address = bus0.address;  assign bus3.chipselect = bus0.chipselect;
  assign bus3.write_n = bus0.write_n;  assign bus3.writedata  = bus0.writedata;

  logic irq0, irq1, irq2, irq3;
  logic [31:0] rd [4];
  wire  [3:0]  irq_w = {irq3, irq2, irq1, irq0};

  assign rd[0] = bus0.readdata;
  assign rd[1] = bus1.readdata;
  assign rd[2] = bus2.readdata;
  assign rd[3] = bus3.readdata;

  avalon_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0))
    u_b0 (.clk(clk), .reset(rst), .bus(bus0), .in_port(in_port), .irq(irq0));
  avalon_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0))
    u_d4 (.clk(clk), .reset(rst), .bus(bus1), .in_port(in_port), .irq(irq1));
  avalon_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1))
    u_m1 (.clk(clk), .reset(rst), .bus(bus2), .in_port(in_port), .irq(irq2));
  avalon_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2))
    u_m2 (.clk(clk), .reset(rst), .bus(bus3), .in_port(in_port), .irq(irq3));

  always #5 clk = ~clk;

  // Reference model. Debounce is expressed as a window rule: a bit takes the
  // synchronized level once the last N sampled levels all differ from it.
  int         m_db   [4] = '{0, 4, 0, 0};
  int         m_mode [4] = '{0, 0, 1, 2};
  logic [7:0] m_p1 [4], m_sync [4], m_stab [4], m_edge [4], m_mask [4];
  logic [7:0] m_win [4][4];
  logic [31:0] m_rd [4];
  logic        m_irq [4];

  initial begin
    logic [7:0] ns, ev, clr, nm, ne;
    logic       wr, all_diff;
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          m_p1[i] = '0; m_sync[i] = '0; m_stab[i] = '0; m_edge[i] = '0;
          m_mask[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
          for (int k = 0; k < 4; k++) m_win[i][k] = '0;
        end else begin
          for (int k = 3; k > 0; k--) m_win[i][k] = m_win[i][k-1];
          m_win[i][0] = m_sync[i];
          ns = m_stab[i];
          if (m_db[i] == 0) begin
            ns = m_sync[i];
          end else begin
            for (int b = 0; b < 8; b++) begin
              all_diff = 1'b1;
              for (int k = 0; k < m_db[i]; k++)
                if (m_win[i][k][b] == m_stab[i][b]) all_diff = 1'b0;
              if (all_diff) ns[b] = m_sync[i][b];
            end
          end
          case (m_mode[i])
            0:       ev = ns & ~m_stab[i];
            1:       ev = ~ns & m_stab[i];
            default: ev = ns ^ m_stab[i];
          endcase
          wr  = bus0.chipselect && !bus0.write_n;
          clr = (wr && bus0.address == 2'd3) ? bus0.writedata[7:0] : 8'h00;
          nm  = (wr && bus0.address == 2'd2) ? bus0.writedata[7:0] : m_mask[i];
          ne  = (m_edge[i] & ~clr) | ev;
          case (bus0.address)
            2'd0:    m_rd[i] = {24'h0, m_stab[i]};
            2'd2:    m_rd[i] = {24'h0, m_mask[i]};
            2'd3:    m_rd[i] = {24'h0, m_edge[i]};
            default: m_rd[i] = 32'h0;
          endcase
          m_irq[i]  = |(ne & nm);
          m_stab[i] = ns;
          m_edge[i] = ne;
          m_mask[i] = nm;
          m_sync[i] = m_p1[i];
          m_p1[i]   = in_port;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    step(1);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
  endtask

  task automatic settle_clear();
    step(8);
    bus_write(2'd3, 32'hFF);
    step(1);
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd[i] !== 32'h0) begin fails++; $display("FAIL reset_rd inst%0d: got %h want %h", i, rd[i], 32'h0); end
      tests++;
      if (irq_w[i] !== 1'b0) begin fails++; $display("FAIL reset_irq inst%0d: got %b want 0", i, irq_w[i]); end
    end
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_sync_latency();
    bus0.address = 2'd0;
    in_port = 8'hA5;
    step(3);
    tests++;
    if (rd[0] !== 32'h0) begin fails++; $display("FAIL sync_early: got %h want %h", rd[0], 32'h0); end
    step(1);
    tests++;
    if (rd[0] !== 32'hA5) begin fails++; $display("FAIL sync_data: got %h want %h", rd[0], 32'hA5); end
    bus0.address = 2'd3;
    step(1);
    tests++;
    if (rd[0] !== 32'hA5) begin fails++; $display("FAIL sync_capture_rise: got %h want %h", rd[0], 32'hA5); end
    tests++;
    if (rd[2] !== 32'h0) begin fails++; $display("FAIL sync_capture_fall: got %h want %h", rd[2], 32'h0); end
    tests++;
    if (rd[3] !== 32'hA5) begin fails++; $display("FAIL sync_capture_any: got %h want %h", rd[3], 32'hA5); end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_debounce();
    bus0.address = 2'd0;
    in_port = 8'h01;
    step(3);
    in_port = 8'h00;
    step(10);
    tests++;
    if (rd[1] !== 32'h0) begin fails++; $display("FAIL db_glitch_data: got %h want %h", rd[1], 32'h0); end
    bus0.address = 2'd3;
    step(1);
    tests++;
    if (rd[1] !== 32'h0) begin fails++; $display("FAIL db_glitch_capture: got %h want %h", rd[1], 32'h0); end
    bus0.address = 2'd0;
    in_port = 8'h01;
    step(6);
    tests++;
    if (rd[1] !== 32'h0) begin fails++; $display("FAIL db_early: got %h want %h", rd[1], 32'h0); end
    step(1);
    tests++;
    if (rd[1] !== 32'h1) begin fails++; $display("FAIL db_accept: got %h want %h", rd[1], 32'h1); end
    bus0.address = 2'd3;
    step(1);
    tests++;
    if (rd[1] !== 32'h1) begin fails++; $display("FAIL db_capture: got %h want %h", rd[1], 32'h1); end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_irq();
    bus_write(2'd2, 32'h01);
    bus0.address = 2'd3;
    in_port = 8'h01;
    step(2);
    tests++;
    if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_early: got %b want 0", irq0); end
    step(1);
    tests++;
    if (irq0 !== 1'b1) begin fails++; $display("FAIL irq_assert: got %b want 1", irq0); end
    bus_write(2'd3, 32'h01);
    tests++;
    if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq0); end
    step(1);
    tests++;
    if (rd[0] !== 32'h0) begin fails++; $display("FAIL irq_capture_cleared: got %h want %h", rd[0], 32'h0); end
    bus_write(2'd2, 32'h00);
    in_port = 8'h00;
    step(8);
    in_port = 8'h01;
    for (int c = 0; c < 10; c++) begin
      step(1);
      tests++;
      if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_masked cyc%0d: got %b want 0", c, irq0); end
    end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_set_wins();
    in_port = 8'h04;
    step(2);
    bus0.address = 2'd3; bus0.writedata = 32'h04; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    step(1);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    step(1);
    tests++;
    if (rd[0] !== 32'h04) begin fails++; $display("FAIL set_wins_rise: got %h want %h", rd[0], 32'h04); end
    tests++;
    if (rd[3] !== 32'h04) begin fails++; $display("FAIL set_wins_any: got %h want %h", rd[3], 32'h04); end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_modes();
    in_port = 8'h08;
    settle_clear();
    bus0.address = 2'd3;
    in_port = 8'h00;
    step(8);
    tests++;
    if (rd[0] !== 32'h00) begin fails++; $display("FAIL mode0_fall: got %h want %h", rd[0], 32'h00); end
    tests++;
    if (rd[2] !== 32'h08) begin fails++; $display("FAIL mode1_fall: got %h want %h", rd[2], 32'h08); end
    tests++;
    if (rd[3] !== 32'h08) begin fails++; $display("FAIL mode2_fall: got %h want %h", rd[3], 32'h08); end
    bus_write(2'd3, 32'hFF);
    in_port = 8'h08;
    step(8);
    tests++;
    if (rd[0] !== 32'h08) begin fails++; $display("FAIL mode0_rise: got %h want %h", rd[0], 32'h08); end
    tests++;
    if (rd[2] !== 32'h00) begin fails++; $display("FAIL mode1_rise: got %h want %h", rd[2], 32'h00); end
    tests++;
    if (rd[3] !== 32'h08) begin fails++; $display("FAIL mode2_rise: got %h want %h", rd[3], 32'h08); end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_reset_mid_debounce();
    bus_write(2'd2, 32'hFF);
    bus0.address = 2'd0;
    in_port = 8'h01;
    step(5);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd[i] !== 32'h0) begin fails++; $display("FAIL midrst_rd inst%0d: got %h want %h", i, rd[i], 32'h0); end
      tests++;
      if (irq_w[i] !== 1'b0) begin fails++; $display("FAIL midrst_irq inst%0d: got %b want 0", i, irq_w[i]); end
    end
    @(negedge clk);
    rst = 1'b0;
    step(6);
    tests++;
    if (rd[1] !== 32'h0) begin fails++; $display("FAIL midrst_partial: got %h want %h", rd[1], 32'h0); end
    step(1);
    tests++;
    if (rd[1] !== 32'h1) begin fails++; $display("FAIL midrst_full: got %h want %h", rd[1], 32'h1); end
    in_port = 8'h00;
    settle_clear();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rd[i] !== m_rd[i]) begin fails++; $display("FAIL rand_rd inst%0d cyc%0d: got %h want %h", i, c, rd[i], m_rd[i]); end
        tests++;
        if (irq_w[i] !== m_irq[i]) begin fails++; $display("FAIL rand_irq inst%0d cyc%0d: got %b want %b", i, c, irq_w[i], m_irq[i]); end
      end
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
      bus0.address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = $urandom;
      end else begin
        bus0.chipselect = 1'($urandom_range(0, 1)); bus0.write_n = 1'b1;
      end
      step(1);
    end
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
  endtask

  initial begin
    in_port         = 8'h00;
    bus0.address    = 2'd0;
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
    bus0.writedata  = 32'h0;
    test_reset();
    test_sync_latency();
    test_debounce();
    test_irq();
    test_set_wins();
    test_modes();
    test_reset_mid_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_pio_in_edge.md
AVALON_PIO_IN_EDGE -- requirements
Module: avalon_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 8, input port width; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per bit; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0, consecutive stable cycles required before accepting a change; 0 = bypass; legal range 0..65535.
REQ-004 Parameter EDGE_MODE, default 0, capture type: 0 rising, 1 falling, 2 any edge.
REQ-005 clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select, qualifies writes.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs (switches/buttons).
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 The block SHALL pass each in_port bit through SYNC_STAGES flops; sync value = last stage.
REQ-015 With DEBOUNCE_CYCLES=0, the stable value SHALL load the sync value every cycle.
REQ-016 With DEBOUNCE_CYCLES=N>0, each bit SHALL own a 16-bit counter: cleared on any cycle where sync equals stable; incremented otherwise; when sync differs from stable and counter equals N-1, stable bit SHALL take sync and counter SHALL clear on that edge.
REQ-017 A glitch shorter than N cycles SHALL clear the counter and leave stable unchanged.
REQ-018 Edge event: on the clock edge where a stable bit changes 0->1 (mode 0), 1->0 (mode 1), or either (mode 2), the matching edgecapture bit SHALL be set on that same edge.
REQ-019 Register map (word addresses): 0 data (RO, stable value), 1 reserved (reads 0, writes ignored), 2 irqmask (RW, WIDTH bits), 3 edgecapture (R, write-1-to-clear).
REQ-020 Write SHALL occur when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] used.
REQ-021 Writing address 3 SHALL clear each edgecapture bit whose writedata bit is 1; bits with 0 unchanged.
REQ-022 Simultaneous edge event and W1C clear on the same bit SHALL leave the bit set (set wins).
REQ-023 readdata SHALL update every clock to the addressed register zero-extended to 32 bits (read latency 1, no chipselect qualification).
REQ-024 irq SHALL be registered: irq <= |(edgecapture_next & irqmask_next), i.e. asserted the cycle after the causing edge and deasserted the cycle after clear or mask.
REQ-025 Bits above WIDTH SHALL always read 0.

Reset
REQ-026 While reset=1: sync flops, stable, counters, edgecapture, irqmask, readdata and irq SHALL all be 0, asynchronously.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured from the pre-reset state.
REQ-028 After reset release, a port held at 1 SHALL appear in data and, in modes 0/2, set edgecapture once the stable value transitions 0->1.

Verification (WIDTH=8, SYNC_STAGES=2, EDGE_MODE=0 unless stated)
REQ-029 DEBOUNCE=0, in_port 0x00->0xA5 at cycle 0, address=0 -> stable=0xA5 after edge 3, readdata=0x000000A5 one cycle later; edgecapture=0xA5.
REQ-030 DEBOUNCE=4, bit0 pulse 3 cycles wide -> data and edgecapture stay 0x00; pulse 6 cycles wide -> data bit0=1 after 2+4 edges, edgecapture=0x01.
REQ-031 irqmask=0x01, bit0 rising -> irq=1 one cycle after capture; write 0x01 to address 3 -> edgecapture=0x00, irq=0 next cycle; irqmask=0x00 -> irq never asserts.
REQ-032 W1C of bit2 issued on the same edge bit2 captures -> edgecapture bit2 remains 1.
REQ-033 EDGE_MODE=1 then 2: bit3 toggles 1->0->1 -> mode 1 captures once on fall; mode 2 captures on both (clear between).
REQ-034 Reset asserted during a 3-of-4 debounce count -> all outputs 0 immediately; after release, data=0x00 until a full new debounce completes.
